serial_tagger: RTL and testbench

Upstream stage of the reorder buffer. Accepts an in-order data stream, stamps every beat with a wrapping serial number, and emits it as a tagged stream toward the parallel/shuffling section whose output the reorder buffer restores. It holds a credit count of beats tagged but not yet retired by the reorder buffer. It stalls input once `DEPTH` beats are outstanding, so serials are never reused while still live and the always-ready reorder buffer cannot be overrun.

---
 rtl/serial_tagger.sv | 127 ++++++++++++
 tb/tb_serial_tagger.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tagger.sv
// serial_tagger: stamps each in-order beat with a wrapping serial number and
// forwards it through a two-entry output stage (output register + skid).
// A credit counter limits beats in flight to DEPTH, so a serial is never reused
// while the reorder buffer downstream still holds a beat carrying it.
module serial_tagger #(
   parameter type data_t       = logic [31:0],
   parameter int  KEEP_WIDTH   = 4,
   parameter int  DEPTH        = 8,
   parameter int  SERIAL_WIDTH = $clog2(DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   // untagged input stream
   input  data_t                   in_data,
   input  logic [KEEP_WIDTH-1:0]   in_keep,
   input  logic                    in_last,
   input  logic                    in_valid,
   output logic                    in_ready,
   // tagged output stream
   output data_t                   out_data,
   output logic [KEEP_WIDTH-1:0]   out_keep,
   output logic                    out_last,
   output logic [SERIAL_WIDTH-1:0] out_tag,
   output logic                    out_valid,
   input  logic                    out_ready,
   // credit return from the reorder buffer
   input  logic                    retire,
   output logic [SERIAL_WIDTH:0]   outstanding,
   output logic                    underflow
);

   // Reject parameter sets where the tag space does not match the window.
   if ((DEPTH < 2) || (DEPTH != (1 << SERIAL_WIDTH))) begin : g_bad_params
      $error("serial_tagger: DEPTH must be a power of two >= 2 and equal 2**SERIAL_WIDTH");
   end

   localparam logic [SERIAL_WIDTH:0] CREDIT_MAX = (SERIAL_WIDTH + 1)'(DEPTH);

   typedef struct packed {
      data_t                   data;
      logic [KEEP_WIDTH-1:0]   keep;
      logic                    last;
      logic [SERIAL_WIDTH-1:0] tag;
   } beat_t;

   beat_t                   out_reg;
   beat_t                   skid_reg;
   beat_t                   new_beat;
   logic                    skid_valid;
   logic [SERIAL_WIDTH-1:0] serial;
   logic                    accept;
   logic                    slot_free;

   // in_ready depends only on registers and reset, never on out_ready.
   assign in_ready  = rst_n && !skid_valid && (outstanding != CREDIT_MAX);
   assign accept    = in_valid && in_ready;
   assign slot_free = !out_valid || out_ready;

   assign new_beat.data = in_data;
   assign new_beat.keep = in_keep;
   assign new_beat.last = in_last;
   assign new_beat.tag  = serial;

   assign out_data = out_reg.data;
   assign out_keep = out_reg.keep;
   assign out_last = out_reg.last;
   assign out_tag  = out_reg.tag;

   // Occupancy of the output register and skid, plus the serial counter.
   // NOTE: reset is synchronous, so rst_n is sampled inside the posedge block and
   // stays out of the sensitivity list; state uses <= so every register in the
   // block sees pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
         serial     <= '0;
      end else begin
         if (slot_free) begin
            if (skid_valid) begin
               out_valid  <= 1'b1;
               skid_valid <= 1'b0;
            end else begin
               out_valid <= accept;
            end
         end else if (accept) begin
            skid_valid <= 1'b1;
         end
         if (accept) begin
            serial <= serial + 1'b1;
         end
      end
   end

   // Payload movement through the output register and skid.
   // NOTE: payload registers are deliberately not reset; the valid flags above
   // qualify them, and leaving them out of reset keeps the reset net small.
   always_ff @(posedge clk) begin
      if (slot_free) begin
         if (skid_valid) begin
            out_reg <= skid_reg;
         end else if (accept) begin
            out_reg <= new_beat;
         end
      end else if (accept) begin
         skid_reg <= new_beat;
      end
   end

   // Credit counter: +1 per accept, -1 per retire, sticky flag on retire at zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         outstanding <= '0;
         underflow   <= 1'b0;
      end else begin
         case ({accept, retire})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   if (outstanding != '0) outstanding <= outstanding - 1'b1;
            default: ;
         endcase
         if (retire && (outstanding == '0)) begin
            underflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_serial_tagger.sv
// Self-checking bench for serial_tagger (DEPTH=8, 16-bit data, 2-bit keep).
// A queue-based model of the beats in flight is compared every cycle; directed
// scenarios add hand-computed literal expectations.
module tb_serial_tagger;

   localparam int DEPTH = 8;
   localparam int SW    = 3;

   logic          clk;
   logic          rst_n;
   logic [15:0]   in_data;
   logic [1:0]    in_keep;
   logic          in_last;
   logic          in_valid;
   logic          in_ready;
   logic [15:0]   out_data;
   logic [1:0]    out_keep;
   logic          out_last;
   logic [SW-1:0] out_tag;
   logic          out_valid;
   logic          out_ready;
   logic          retire;
   logic [SW:0]   outstanding;
   logic          underflow;

   serial_tagger #(
      .data_t       (logic [15:0]),
      .KEEP_WIDTH   (2),
      .DEPTH        (DEPTH),
      .SERIAL_WIDTH (SW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_data     (in_data),
      .in_keep     (in_keep),
      .in_last     (in_last),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .out_data    (out_data),
      .out_keep    (out_keep),
      .out_last    (out_last),
      .out_tag     (out_tag),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .retire      (retire),
      .outstanding (outstanding),
      .underflow   (underflow)
   );

   typedef struct {
      logic [15:0] data;
      logic [1:0]  keep;
      logic        last;
   } src_t;

   typedef struct {
      logic [15:0] data;
      logic [1:0]  keep;
      logic        last;
      int          tag;
   } beat_t;

   int    checks = 0;
   int    errors = 0;
   src_t  src_q[$];
   beat_t held[$];      // model: beats accepted and not yet handed off
   beat_t emitted[$];   // DUT beats observed leaving, in order
   int    m_credits;
   int    m_serial;
   bit    m_under;
   bit    model_valid = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Source driver: presents the head of src_q, pops it after a handshake.
   initial begin
      logic hs;
      in_valid = 1'b0;
      in_data  = '0;
      in_keep  = '0;
      in_last  = 1'b0;
      forever begin
         @(negedge clk);
         hs = in_valid && in_ready;
         @(posedge clk);
         #1;
         if (hs && (src_q.size() > 0)) void'(src_q.pop_front());
         if (src_q.size() > 0) begin
            in_valid = 1'b1;
            in_data  = src_q[0].data;
            in_keep  = src_q[0].keep;
            in_last  = src_q[0].last;
         end else begin
            in_valid = 1'b0;
         end
      end
   end

   // Model compare and advance, once per cycle on the falling edge.
   initial begin
      bit    exp_ready;
      bit    acc;
      beat_t b;
      forever begin
         @(negedge clk);
         exp_ready = rst_n && (held.size() < 2) && (m_credits < DEPTH);
         if (model_valid) begin
            check("in_ready", in_ready, exp_ready);
            check("out_valid", out_valid, held.size() > 0);
            if (held.size() > 0) begin
               check("out_data", out_data, held[0].data);
               check("out_keep", out_keep, held[0].keep);
               check("out_last", out_last, held[0].last);
               check("out_tag", out_tag, held[0].tag);
            end
            check("outstanding", outstanding, m_credits);
            check("underflow", underflow, m_under);
            if (out_valid && out_ready && rst_n) begin
               b.data = out_data;
               b.keep = out_keep;
               b.last = out_last;
               b.tag  = out_tag;
               emitted.push_back(b);
            end
         end
         acc = in_valid && exp_ready;
         if (!rst_n) begin
            held.delete();
            m_credits   = 0;
            m_serial    = 0;
            m_under     = 1'b0;
            model_valid = 1'b1;
         end else begin
            if ((held.size() > 0) && out_ready) void'(held.pop_front());
            if (acc) begin
               b.data = in_data;
               b.keep = in_keep;
               b.last = in_last;
               b.tag  = m_serial;
               held.push_back(b);
               m_serial = (m_serial + 1) % DEPTH;
            end
            if (retire && (m_credits == 0)) m_under = 1'b1;
            if (acc && !retire) m_credits++;
            else if (!acc && retire && (m_credits > 0)) m_credits--;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic push(input logic [15:0] d);
      src_t s;
      s.data = d;
      s.keep = d[1:0];
      s.last = d[0];
      src_q.push_back(s);
   endtask

   // Directed scenarios with literal expectations.
   initial begin
      rst_n     = 1'b0;
      out_ready = 1'b0;
      retire    = 1'b0;
      ticks(2);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_outstanding", outstanding, 0);
      check("rst_underflow", underflow, 1'b0);
      check("rst_in_ready", in_ready, 1'b0);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      tick();

      // Credit exhaustion: 10 beats, no retire.
      for (int i = 0; i < 10; i++) push(16'h0100 + 16'(i));
      ticks(14);
      check("exh_outstanding", outstanding, 8);
      check("exh_in_ready", in_ready, 1'b0);
      check("exh_emitted", emitted.size(), 8);
      check("exh_first_tag", emitted[0].tag, 0);
      check("exh_last_tag", emitted[7].tag, 7);
      check("exh_held_upstream", src_q.size(), 2);

      // One retire frees a credit; beat 9 goes out with tag 0.
      retire = 1'b1;
      tick();
      retire = 1'b0;
      check("wrap_in_ready", in_ready, 1'b1);
      ticks(4);
      check("wrap_outstanding", outstanding, 8);
      check("wrap_emitted", emitted.size(), 9);
      check("wrap_tag", emitted[8].tag, 0);
      check("wrap_data", emitted[8].data, 16'h0108);

      // Drain all credits (beat 10 slips in along the way).
      retire = 1'b1;
      ticks(9);
      retire = 1'b0;
      tick();
      check("drain_outstanding", outstanding, 0);
      check("drain_underflow", underflow, 1'b0);
      check("drain_tag", emitted[9].tag, 1);

      // Backpressure: A,B,C,D with out_ready low.
      out_ready = 1'b0;
      push(16'h000A);
      push(16'h000B);
      push(16'h000C);
      push(16'h000D);
      ticks(5);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_out_data", out_data, 16'h000A);
      check("bp_out_tag", out_tag, 2);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_outstanding", outstanding, 2);
      out_ready = 1'b1;
      ticks(8);
      check("bp_emitted", emitted.size(), 14);
      for (int i = 0; i < 4; i++) begin
         check("bp_order_data", emitted[10 + i].data, 16'h000A + 16'(i));
         check("bp_order_tag", emitted[10 + i].tag, 2 + i);
      end
      retire = 1'b1;
      ticks(4);
      retire = 1'b0;
      tick();
      check("bp_drained", outstanding, 0);

      // Simultaneous accept and retire at outstanding 5.
      for (int i = 0; i < 5; i++) push(16'h0200 + 16'(i));
      ticks(10);
      check("sim_pre", outstanding, 5);
      push(16'h0300);
      tick();
      retire = 1'b1;
      tick();
      retire = 1'b0;
      ticks(3);
      check("sim_outstanding", outstanding, 5);
      check("sim_tag", emitted[emitted.size() - 1].tag, 3);
      check("sim_data", emitted[emitted.size() - 1].data, 16'h0300);
      retire = 1'b1;
      ticks(5);
      retire = 1'b0;
      tick();
      check("sim_drained", outstanding, 0);

      // Underflow: retire at zero credits.
      retire = 1'b1;
      tick();
      retire = 1'b0;
      tick();
      check("uf_outstanding", outstanding, 0);
      check("uf_flag", underflow, 1'b1);
      ticks(3);
      check("uf_sticky", underflow, 1'b1);

      // Reset mid-stream with output and skid full, outstanding 6.
      for (int i = 0; i < 4; i++) push(16'h0400 + 16'(i));
      ticks(8);
      check("mr_pre4", outstanding, 4);
      out_ready = 1'b0;
      push(16'h0500);
      push(16'h0501);
      push(16'h0502);
      ticks(6);
      check("mr_outstanding", outstanding, 6);
      check("mr_out_valid", out_valid, 1'b1);
      check("mr_out_tag", out_tag, 0);
      check("mr_in_ready", in_ready, 1'b0);
      rst_n = 1'b0;
      tick();
      check("mr_rst_out_valid", out_valid, 1'b0);
      check("mr_rst_outstanding", outstanding, 0);
      check("mr_rst_underflow", underflow, 1'b0);
      check("mr_rst_in_ready", in_ready, 1'b0);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      ticks(4);
      check("mr_post_tag", emitted[emitted.size() - 1].tag, 0);
      check("mr_post_data", emitted[emitted.size() - 1].data, 16'h0502);
      check("mr_post_outstanding", outstanding, 1);

      retire = 1'b1;
      tick();
      retire = 1'b0;
      ticks(2);
      check("end_outstanding", outstanding, 0);
      check("end_src_empty", src_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
